// File: rtl/alu_arbiter_if.sv
// Bundle of the two-requester operand buses and the shared response channel.
// Latency: none, wires only.
// Backpressure: req_ready per requester, rsp_ready from the response consumer.
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_A0;
    logic [63:0] req_B0;
    logic [63:0] req_A1;
    logic [63:0] req_B1;
    logic [2:0]  req_cntrl0;
    logic [2:0]  req_cntrl1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    // Requesters and response consumer side
    modport master (
        output req_valid, req_A0, req_B0, req_A1, req_B1, req_cntrl0, req_cntrl1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_A0, req_B0, req_A1, req_B1, req_cntrl0, req_cntrl1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one 64-bit combinational ALU through a round-robin grant.
// Latency: rsp_valid rises two edges after the request transfer edge.
// Backpressure: one op in flight; req_ready stays 00 until the response handshake.

// 64-bit combinational ALU: pass B, add, sub, and, or, xor; 001/111 flag an error.
module alu (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [2:0]  cntrl,
    output logic [63:0] result,
    output logic [3:0]  flags,
    output logic        err
);
    logic        sub;
    logic [63:0] b_eff;
    logic [64:0] sum;
    logic        ovf;
    logic        cout;

    // Shared adder does subtraction as a + ~b + 1, so carry_out on sub means "no borrow"
    always_comb begin
        sub    = (cntrl == 3'b011);
        b_eff  = sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {64'd0, sub};
        result = 64'd0;
        ovf    = 1'b0;
        cout   = 1'b0;
        err    = 1'b0;
        case (cntrl)
            3'b000: result = b;
            3'b010,
            3'b011: begin
                result = sum[63:0];
                cout   = sum[64];
                ovf    = (a[63] == b_eff[63]) && (sum[63] != a[63]);
            end
            3'b100: result = a & b;
            3'b101: result = a | b;
            3'b110: result = a ^ b;
            default: err = 1'b1;
        endcase
        flags = err ? 4'b0000 : {result[63], (result == 64'd0), ovf, cout};
    end
endmodule

module alu_arbiter (
    input  logic           clk,
    input  logic           reset,
    alu_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        grant_any;
    logic        grant_id;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [2:0]  op_cntrl;
    logic        op_id;
    logic [63:0] alu_result;
    logic [3:0]  alu_flags;
    logic        alu_err;

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .cntrl  (op_cntrl),
        .result (alu_result),
        .flags  (alu_flags),
        .err    (alu_err)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grant selection and next state; ready is masked while reset is held
    always_comb begin
        state_nxt     = state;
        grant_any     = 1'b0;
        grant_id      = 1'b0;
        bus.req_ready = 2'b00;
        case (state)
            IDLE: begin
                case (bus.req_valid)
                    2'b01:   grant_id = 1'b0;
                    2'b10:   grant_id = 1'b1;
                    2'b11:   grant_id = ~last_grant;
                    default: grant_id = 1'b0;
                endcase
                grant_any = (bus.req_valid != 2'b00) && !reset;
                if (grant_any) begin
                    bus.req_ready = grant_id ? 2'b10 : 2'b01;
                    state_nxt     = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the granted requester's operands; only the transfer edge samples inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a       <= 64'd0;
            op_b       <= 64'd0;
            op_cntrl   <= 3'd0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_any) begin
            op_a       <= grant_id ? bus.req_A1 : bus.req_A0;
            op_b       <= grant_id ? bus.req_B1 : bus.req_B0;
            op_cntrl   <= grant_id ? bus.req_cntrl1 : bus.req_cntrl0;
            op_id      <= grant_id;
            last_grant <= grant_id;
        end
    end

    // Register the ALU outcome at the end of EXEC and hold it until the consumer takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= 64'd0;
            bus.rsp_flags  <= 4'b0000;
            bus.rsp_err    <= 1'b0;
            bus.rsp_id     <= 1'b0;
        end else if (state == EXEC) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_result <= alu_result;
            bus.rsp_flags  <= alu_flags;
            bus.rsp_err    <= alu_err;
            bus.rsp_id     <= op_id;
        end else if (state == RESP && bus.rsp_ready) begin
            bus.rsp_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level model.
// Latency: model expects rsp_valid two edges after each accept.
// Backpressure: rsp_ready is randomized; stalls are checked for stable outputs.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();
    alu_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_bad = 0;

    // Requester-side pending operations
    logic        pend_v  [2];
    logic [63:0] pend_a  [2];
    logic [63:0] pend_b  [2];
    logic [2:0]  pend_op [2];
    logic        rr;

    // Transaction model: one op in flight, remembered winner for contention
    bit          busy;
    int          age;
    logic        last_w;
    logic [63:0] e_res;
    logic [3:0]  e_flg;
    logic        e_err;
    logic        e_id;

    // Observed responses at their handshake edges
    int          r_id  [$];
    logic [63:0] r_res [$];
    logic [3:0]  r_flg [$];
    logic        r_err [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference ALU from arithmetic definitions: exact 65-bit signed sum for overflow
    function automatic void ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                                    output logic [63:0] r, output logic [3:0] f, output logic e);
        logic [64:0] s;
        logic v;
        logic c;
        r = 64'd0; v = 1'b0; c = 1'b0; e = 1'b0;
        case (op)
            3'd0: r = b;
            3'd2: begin
                s = {a[63], a} + {b[63], b};
                r = a + b;
                v = (s[64] != s[63]);
                c = (r < a);
            end
            3'd3: begin
                s = {a[63], a} - {b[63], b};
                r = a - b;
                v = (s[64] != s[63]);
                c = (a >= b);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: e = 1'b1;
        endcase
        f = e ? 4'b0000 : {r[63], (r == 64'd0), v, c};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic new_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        pend_v[i] = 1'b1; pend_a[i] = a; pend_b[i] = b; pend_op[i] = op;
    endtask

    task automatic clr_log();
        r_id.delete(); r_res.delete(); r_flg.delete(); r_err.delete();
    endtask

    // One clock: drive, check against model mid-cycle, take the edge, advance model
    task automatic cycle();
        logic [1:0]  want;
        logic [1:0]  exp_rdy;
        int          g;
        bit          hs;
        logic        o_id;
        logic [63:0] o_res;
        logic [3:0]  o_flg;
        logic        o_err;
        bus.req_valid  = {pend_v[1], pend_v[0]};
        bus.req_A0     = pend_a[0];  bus.req_B0 = pend_b[0];  bus.req_cntrl0 = pend_op[0];
        bus.req_A1     = pend_a[1];  bus.req_B1 = pend_b[1];  bus.req_cntrl1 = pend_op[1];
        bus.rsp_ready  = rr;
        #1;
        want = bus.req_valid;
        exp_rdy = 2'b00;
        g = -1;
        if (!busy) begin
            if (want == 2'b01)      g = 0;
            else if (want == 2'b10) g = 1;
            else if (want == 2'b11) g = (last_w == 1'b1) ? 0 : 1;
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", bus.req_ready, exp_rdy);
        hs = 1'b0;
        o_id = bus.rsp_id; o_res = bus.rsp_result; o_flg = bus.rsp_flags; o_err = bus.rsp_err;
        if (busy && age >= 2) begin
            chk("rsp_valid_hi", bus.rsp_valid, 1);
            chk("rsp_id", o_id, e_id);
            chk("rsp_result", o_res, e_res);
            chk("rsp_flags", o_flg, e_flg);
            chk("rsp_err", o_err, e_err);
            hs = rr;
        end else begin
            chk("rsp_valid_lo", bus.rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        if (hs) begin
            busy = 1'b0;
            r_id.push_back(int'(o_id)); r_res.push_back(o_res);
            r_flg.push_back(o_flg);     r_err.push_back(o_err);
        end else if (busy) begin
            age++;
        end
        if (g >= 0) begin
            busy = 1'b1;
            age = 1;
            last_w = g[0];
            e_id = g[0];
            ref_alu(pend_a[g], pend_b[g], pend_op[g], e_res, e_flg, e_err);
            pend_v[g] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_flags", bus.rsp_flags, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        busy = 1'b0;
        age = 0;
        last_w = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && r_res.size() < n; k++) cycle();
        chk(tag, r_res.size(), n);
    endtask

    task automatic drain();
        pend_v[0] = 1'b0; pend_v[1] = 1'b0; rr = 1'b1;
        for (int k = 0; k < 10 && busy; k++) cycle();
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 1'b0; pend_a[i] = 64'd0; pend_b[i] = 64'd0; pend_op[i] = 3'd0;
        end
        rr = 1'b1;
        busy = 1'b0; age = 0; last_w = 1'b1;
        e_res = 64'd0; e_flg = 4'd0; e_err = 1'b0; e_id = 1'b0;
        bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
        bus.req_A0 = 64'd0; bus.req_B0 = 64'd0; bus.req_A1 = 64'd0; bus.req_B1 = 64'd0;
        bus.req_cntrl0 = 3'd0; bus.req_cntrl1 = 3'd0;
        #2;
        do_reset();

        // Single add from requester 0 right after reset
        clr_log();
        new_op(0, 64'h1, 64'h1, 3'b010);
        run_until(1, 10, "add_cnt");
        if (r_res.size() >= 1) begin
            chk("add_res", r_res[0], 64'h2);
            chk("add_flg", r_flg[0], 4'b0000);
            chk("add_id", r_id[0], 0);
            chk("add_err", r_err[0], 0);
        end

        // First contention after reset goes to requester 0
        do_reset();
        clr_log();
        new_op(0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0001, 3'b010);
        new_op(1, 64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000, 3'b011);
        run_until(2, 20, "cont_cnt");
        if (r_res.size() >= 2) begin
            chk("cont0_id", r_id[0], 0);
            chk("cont0_res", r_res[0], 64'h8000_0000_0000_0001);
            chk("cont0_flg", r_flg[0], 4'b1010);
            chk("cont1_id", r_id[1], 1);
            chk("cont1_res", r_res[1], 64'h0);
            chk("cont1_flg", r_flg[1], 4'b0101);
        end

        // Both continuously valid: strict alternation
        clr_log();
        for (int k = 0; k < 80 && r_res.size() < 6; k++) begin
            for (int i = 0; i < 2; i++)
                if (!pend_v[i]) new_op(i, rnd64(), rnd64(), 3'($urandom_range(0, 7)));
            cycle();
        end
        chk("rr_cnt", r_res.size(), 6);
        for (int k = 0; k < 6 && k < r_res.size(); k++) chk("rr_id", r_id[k], k % 2);
        drain();

        // Invalid op from requester 1
        clr_log();
        new_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111);
        run_until(1, 10, "inv_cnt");
        if (r_res.size() >= 1) begin
            chk("inv_res", r_res[0], 64'h0);
            chk("inv_flg", r_flg[0], 4'b0000);
            chk("inv_err", r_err[0], 1);
            chk("inv_id", r_id[0], 1);
        end

        // Response stall of 5 cycles with the other requester waiting
        clr_log();
        rr = 1'b0;
        new_op(0, rnd64(), rnd64(), 3'b110);
        new_op(1, rnd64(), rnd64(), 3'b101);
        cycle();
        cycle();
        repeat (5) cycle();
        chk("stall_cnt", r_res.size(), 0);
        rr = 1'b1;
        cycle();
        chk("stall_drain", r_res.size(), 1);
        run_until(2, 10, "stall_next");

        // Reset during EXEC discards the op and restores requester 0 priority
        drain();
        do_reset();
        clr_log();
        new_op(0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b100);
        cycle();
        chk("exec_accepted", busy, 1);
        do_reset();
        repeat (4) cycle();
        chk("no_ghost", r_res.size(), 0);
        new_op(0, 64'd5, 64'd7, 3'b010);
        new_op(1, 64'd5, 64'd7, 3'b101);
        run_until(2, 20, "post_rst_cnt");
        if (r_res.size() >= 2) begin
            chk("post_rst_id0", r_id[0], 0);
            chk("post_rst_res0", r_res[0], 64'd12);
            chk("post_rst_id1", r_id[1], 1);
        end

        // Random traffic, including withdrawal of unaccepted requests
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) == 0)
                    new_op(i, rnd64(), rnd64(), 3'($urandom_range(0, 7)));
                else if (pend_v[i] && !busy && $urandom_range(0, 9) == 0)
                    pend_v[i] = 1'b0;
            end
            rr = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: none; data width fixed at 64 bits, op code width fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; a request transfers when req_valid[i] & req_ready[i] are both high at a rising edge.
REQ-006 req_A0, req_B0, req_A1, req_B1  input  64 each  operands of requester 0 / 1.
REQ-007 req_cntrl0, req_cntrl1  input  3 each  op code: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
REQ-008 rsp_valid  output  1  response valid.
REQ-009 rsp_ready  input  1  response consumer accept.
REQ-010 rsp_id  output  1  index of requester owning the response.
REQ-011 rsp_result  output  64  registered result.
REQ-012 rsp_flags  output  4  {negative, zero, overflow, carry_out}, registered.
REQ-013 rsp_err  output  1  high when the op code was 001 or 111.

Function
REQ-014 Block shall contain one instance of the team's 64-bit combinational alu, shared by both requesters.
REQ-015 FSM states: IDLE, EXEC, RESP; reset state IDLE.
REQ-016 IDLE: grant computed combinationally; req_ready[g]=1 only for granted g, other bit 0; req_ready=00 in EXEC and RESP.
REQ-017 Arbitration: one valid -> that requester; both valid -> requester other than last_grant; last_grant resets to 1 so requester 0 wins first contention.
REQ-018 On transfer: latch A, B, cntrl, id into operand registers, update last_grant, go IDLE->EXEC.
REQ-019 EXEC lasts exactly one cycle; ALU evaluates latched operands; at end of EXEC rsp_result, rsp_flags, rsp_err, rsp_id registered and rsp_valid set; go RESP.
REQ-020 Latency: rsp_valid high on the second rising edge after the request transfer edge.
REQ-021 RESP: rsp_valid and all rsp_* outputs held stable until rsp_valid & rsp_ready at an edge; then rsp_valid clears, go IDLE.
REQ-022 Minimum issue interval 3 cycles; no new request accepted before the response handshake completes.
REQ-023 overflow and carry_out shall be forced 0 for ops other than add/sub; negative = result[63], zero = (result == 0) for all valid ops.
REQ-024 Invalid op (001, 111): rsp_result = 0, rsp_flags = 0000, rsp_err = 1; timing identical to valid ops.
REQ-025 Requesters shall hold req_valid and operands stable until accepted; block shall not sample unaccepted inputs.
REQ-026 A requester deasserting req_valid in IDLE before acceptance shall not be granted nor update last_grant.

Reset
REQ-027 reset asserted at any time shall immediately force state IDLE, req_ready=00, rsp_valid=0, rsp_result=0, rsp_flags=0000, rsp_err=0, rsp_id=0, last_grant=1, operand registers 0.
REQ-028 An operation in EXEC or RESP at reset assertion shall be discarded; no response for it after reset release.
REQ-029 First grant possible on the first rising edge after reset deasserts.

Verification
REQ-030 Req0 add A=0x1, B=0x1, rsp_ready=1 -> rsp_valid 2 edges after transfer, result 0x2, flags 0000, rsp_id 0, rsp_err 0.
REQ-031 Both valid after reset, req0 add 0x4000000000000000+0x4000000000000001, req1 sub 0xC000000000000000-0xC000000000000000 -> req0 first: result 0x8000000000000001, flags 1010; then req1: result 0, flags 0101, rsp_id 1.
REQ-032 Both requesters continuously valid for 6 ops -> rsp_id sequence 0,1,0,1,0,1.
REQ-033 Req1 op 111, A=B=0xFFFFFFFFFFFFFFFF -> result 0, flags 0000, rsp_err 1.
REQ-034 rsp_ready low 5 cycles in RESP -> rsp_valid and outputs stable, req_ready 00 throughout; response drains on first rsp_ready high edge.
REQ-035 reset pulsed during EXEC of an and op -> all outputs at reset values, no response emitted, next request served normally with requester 0 priority.
